// File: rtl/tx_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package tx_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    GUARD = 2'd3
  } drain_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when the granted request is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  // prio names the requester that wins a tie; it flips to the other side after each accept
  logic prio;

  always_comb begin
    grant = 2'b00;
    if (valid[0] && valid[1]) begin
      grant = prio ? 2'b10 : 2'b01;
    end else begin
      grant = valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (accept) begin
      prio <= ~grant[1];
    end
  end

endmodule

// File: rtl/tx_scheduler.sv
// Owns the FIFO write port (round-robin between two producers) and drains the FIFO into uart_tx.
module tx_scheduler
  import tx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  output logic [DATA_W-1:0] fifo_data_in,
  output logic              fifo_wen,
  input  logic              fifo_full,
  output logic              fifo_ren,
  input  logic [DATA_W-1:0] fifo_data_out,
  input  logic              fifo_empty,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_en,
  input  logic              tx_rdy,
  input  logic              drain_en,
  output logic [CNT_W-1:0]  tx_count
);

  logic [1:0]   grant;
  logic         accept;
  drain_state_t state;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  // Write-side strobes are forced low while reset is held so nothing leaks out mid-reset
  assign accept       = (|grant) & ~fifo_full & ~rst;
  assign req0_ready   = grant[0] & ~fifo_full & ~rst;
  assign req1_ready   = grant[1] & ~fifo_full & ~rst;
  assign fifo_wen     = accept;
  assign fifo_data_in = rst ? '0 : (grant[1] ? req1_data : req0_data);

  // ren and tx_en are decoded from state so the byte reaches uart_tx two cycles after the pop
  assign fifo_ren = (state == IDLE) & drain_en & ~fifo_empty & ~rst;
  assign tx_en    = (state == SEND) & tx_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_ren) state <= FETCH;
        end
        FETCH: begin
          tx_data <= fifo_data_out;
          state   <= SEND;
        end
        SEND: begin
          if (tx_rdy) begin
            tx_count <= tx_count + 1'b1;
            state    <= GUARD;
          end
        end
        GUARD: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// Randomized and directed bench for tx_scheduler against a transaction-level model with a FIFO and uart_tx stand-in.
module tb_tx_scheduler;
  import tx_pkg::*;

  localparam int DW    = DEF_DATA_W;
  localparam int CW    = DEF_CNT_W;
  localparam int DEPTH = 4;

  logic          tb_clk = 1'b0;
  logic          rst;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [DW-1:0] fifo_data_in, fifo_data_out;
  logic          fifo_wen, fifo_full, fifo_ren, fifo_empty;
  logic [DW-1:0] tx_data;
  logic          tx_en, tx_rdy, drain_en;
  logic [CW-1:0] tx_count;

  always #5 tb_clk = ~tb_clk;

  tx_scheduler #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk           (tb_clk),
    .rst           (rst),
    .req0_data     (req0_data),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req1_data     (req1_data),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .fifo_data_in  (fifo_data_in),
    .fifo_wen      (fifo_wen),
    .fifo_full     (fifo_full),
    .fifo_ren      (fifo_ren),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .tx_data       (tx_data),
    .tx_en         (tx_en),
    .tx_rdy        (tx_rdy),
    .drain_en      (drain_en),
    .tx_count      (tx_count)
  );

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  logic [DW-1:0] q[$];
  bit            pop_sched;
  logic [DW-1:0] pop_val;

  bit            hold0, hold1, keep_both, rand_prod;
  logic [DW-1:0] d0, d1;
  int            budget;
  int            busy;
  bit            rdy_low, rand_rdy, drain_req;

  // Model: tie winner, byte popped but not yet sent, and when things happened
  bit            prio;
  bit            inflight;
  int            ren_cyc, last_en;
  logic [DW-1:0] pend, last_sent;
  logic [CW-1:0] mcount;

  int            wr_src[$];
  logic [DW-1:0] wr_dat[$];
  int            ren_log[$];
  int            en_log[$];
  logic [DW-1:0] en_dat[$];

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clearModel();
    q.delete();
    pop_sched = 0;
    prio      = 0;
    inflight  = 0;
    ren_cyc   = -100;
    last_en   = -100;
    pend      = '0;
    last_sent = '0;
    mcount    = '0;
    busy      = 0;
    hold0 = 0; hold1 = 0; keep_both = 0; rand_prod = 0; budget = 0;
    req0_valid = 0; req1_valid = 0;
    fifo_full = 0; fifo_empty = 1;
    tx_rdy = 1;
  endtask

  task automatic applyStimulus();
    if (pop_sched) begin
      fifo_data_out = pop_val;
      pop_sched     = 0;
    end
    fifo_full  = (q.size() >= DEPTH);
    fifo_empty = (q.size() == 0);
    if (rand_prod && budget > 0 && !hold0 && $urandom_range(0, 2) == 0) begin
      hold0 = 1; d0 = 8'($urandom); budget--;
    end
    if (rand_prod && budget > 0 && !hold1 && $urandom_range(0, 2) == 0) begin
      hold1 = 1; d1 = 8'($urandom); budget--;
    end
    if (keep_both) begin
      hold0 = 1; hold1 = 1;
    end
    req0_valid = hold0; req0_data = d0;
    req1_valid = hold1; req1_data = d1;
    drain_en   = drain_req;
    if (busy > 0) begin
      tx_rdy = 0; busy--;
    end else if (rdy_low) begin
      tx_rdy = 0;
    end else if (rand_rdy) begin
      tx_rdy = ($urandom_range(0, 3) != 0);
    end else begin
      tx_rdy = 1;
    end
  endtask

  task automatic checkOutput();
    int            g;
    bit            e_r0, e_r1, e_wen, e_ren, e_en;
    logic [DW-1:0] e_din, e_txd;
    g     = (req0_valid && req1_valid) ? int'(prio) : (req1_valid ? 1 : 0);
    e_r0  = req0_valid && !fifo_full && g == 0;
    e_r1  = req1_valid && !fifo_full && g == 1;
    e_wen = e_r0 || e_r1;
    e_din = (g == 1) ? req1_data : req0_data;
    e_ren = !inflight && (cyc >= last_en + 2) && drain_en && !fifo_empty;
    e_en  = inflight && (cyc >= ren_cyc + 2) && tx_rdy;
    e_txd = (inflight && cyc >= ren_cyc + 2) ? pend : last_sent;

    compare("req0_ready", req0_ready, e_r0);
    compare("req1_ready", req1_ready, e_r1);
    compare("fifo_wen", fifo_wen, e_wen);
    if (req0_valid || req1_valid) compare("fifo_data_in", fifo_data_in, e_din);
    compare("fifo_ren", fifo_ren, e_ren);
    compare("tx_en", tx_en, e_en);
    compare("tx_data", tx_data, e_txd);
    compare("tx_count", tx_count, mcount);

    if (e_wen) begin
      q.push_back(e_din);
      wr_src.push_back(g);
      wr_dat.push_back(e_din);
      prio = (g == 0);
      if (g == 0) hold0 = 0; else hold1 = 0;
    end
    if (e_en) begin
      inflight  = 0;
      last_en   = cyc;
      last_sent = pend;
      mcount    = mcount + 16'd1;
      en_log.push_back(cyc);
      en_dat.push_back(pend);
      busy = $urandom_range(1, 4);
    end
    if (e_ren) begin
      inflight  = 1;
      ren_cyc   = cyc;
      pend      = q.pop_front();
      pop_sched = 1;
      pop_val   = pend;
      ren_log.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge tb_clk);
      #1;
      applyStimulus();
      @(negedge tb_clk);
      checkOutput();
    end
  endtask

  // Reset lands mid-cycle with every input trying to provoke a strobe
  task automatic doReset();
    #2;
    req0_valid = 1; req1_valid = 1; fifo_empty = 0; drain_en = 1;
    rst = 1;
    #1;
    compare("reset_req0_ready", req0_ready, 0);
    compare("reset_req1_ready", req1_ready, 0);
    compare("reset_fifo_wen", fifo_wen, 0);
    compare("reset_fifo_data_in", fifo_data_in, 0);
    compare("reset_fifo_ren", fifo_ren, 0);
    compare("reset_tx_en", tx_en, 0);
    compare("reset_tx_data", tx_data, 0);
    compare("reset_tx_count", tx_count, 0);
    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    clearModel();
    drain_en = drain_req;
    rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int            w0, r0, e0, n0;
    logic [DW-1:0] exp_order[4];
    exp_order = '{8'h11, 8'h22, 8'h11, 8'h22};

    rst = 1;
    req0_data = '0; req1_data = '0; fifo_data_out = '0;
    drain_req = 0; drain_en = 0; rdy_low = 0; rand_rdy = 0;
    d0 = '0; d1 = '0;
    clearModel();
    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    rst = 0;

    // Idle with empty FIFO
    drain_req = 1;
    runCycles(50);
    compare("idle_ren_count", ren_log.size(), 0);
    compare("idle_en_count", en_log.size(), 0);

    // Single byte from producer 0
    hold0 = 1; d0 = 8'hAA;
    runCycles(1);
    compare("single_req0_ready", req0_ready, 1);
    compare("single_fifo_wen", fifo_wen, 1);
    compare("single_fifo_data_in", fifo_data_in, 8'hAA);
    runCycles(8);
    compare("single_ren_count", ren_log.size(), 1);
    compare("single_en_count", en_log.size(), 1);
    if (en_log.size() == 1 && ren_log.size() == 1) begin
      compare("single_latency", en_log[0] - ren_log[0], 2);
      compare("single_tx_byte", en_dat[0], 8'hAA);
    end
    compare("single_tx_count", tx_count, 1);

    // Contention with both held until the FIFO fills
    drain_req = 0;
    doReset();
    d0 = 8'h11; d1 = 8'h22; keep_both = 1;
    w0 = wr_dat.size();
    runCycles(8);
    compare("contention_writes", wr_dat.size() - w0, 4);
    if (wr_dat.size() >= w0 + 4) begin
      n0 = 0;
      for (int k = 0; k < 4; k++) begin
        compare("contention_order", wr_dat[w0 + k], exp_order[k]);
        if (wr_src[w0 + k] == 0) n0++;
      end
      compare("contention_req0_accepts", n0, 2);
      compare("contention_req1_accepts", 4 - n0, 2);
    end
    compare("full_req0_ready", req0_ready, 0);
    compare("full_req1_ready", req1_ready, 0);
    compare("full_fifo_wen", fifo_wen, 0);

    // Release full by draining; req0 resumes next
    drain_req = 1;
    runCycles(6);
    compare("full_resume_writes", (wr_dat.size() - w0) >= 5, 1);
    if (wr_dat.size() >= w0 + 5) compare("full_resume_byte", wr_dat[w0 + 4], 8'h11);
    keep_both = 0;
    runCycles(60);
    compare("contention_drained", fifo_empty, 1);

    // Backpressure while holding 8'h5C in SEND
    rdy_low = 1;
    hold1 = 1; d1 = 8'h5C;
    e0 = en_log.size(); r0 = ren_log.size();
    runCycles(25);
    compare("bp_no_en", en_log.size() - e0, 0);
    compare("bp_one_ren", ren_log.size() - r0, 1);
    compare("bp_tx_data_held", tx_data, 8'h5C);
    rdy_low = 0;
    runCycles(5);
    compare("bp_single_en", en_log.size() - e0, 1);
    if (en_log.size() > e0) compare("bp_sent_byte", en_dat[e0], 8'h5C);

    // 16-byte randomized burst with random uart stalls
    e0 = en_log.size(); r0 = ren_log.size(); w0 = wr_dat.size();
    rand_prod = 1; budget = 16; rand_rdy = 1;
    runCycles(200);
    rand_prod = 0;
    runCycles(100);
    compare("burst_writes", wr_dat.size() - w0, 16);
    compare("burst_sends", en_log.size() - e0, 16);
    compare("burst_reads", ren_log.size() - r0, 16);
    compare("burst_drained", fifo_empty, 1);

    // Pause: drain_en drops during FETCH
    rand_rdy = 0;
    e0 = en_log.size(); r0 = ren_log.size();
    hold0 = 1; d0 = 8'h77;
    for (int k = 0; k < 20 && ren_log.size() == r0; k++) runCycles(1);
    drain_req = 0;
    hold1 = 1; d1 = 8'h78;
    runCycles(20);
    compare("pause_ren_count", ren_log.size() - r0, 1);
    compare("pause_en_count", en_log.size() - e0, 1);
    if (en_log.size() > e0) compare("pause_sent_byte", en_dat[e0], 8'h77);
    compare("pause_fifo_nonempty", fifo_empty, 0);
    drain_req = 1;
    runCycles(10);
    compare("resume_en_count", en_log.size() - e0, 2);
    if (en_log.size() > e0 + 1) compare("resume_sent_byte", en_dat[e0 + 1], 8'h78);

    // Counter wrap
    force dut.tx_count = 16'hFFFE;
    #1;
    release dut.tx_count;
    mcount = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      hold0 = 1; d0 = 8'(k + 1);
      runCycles(8);
    end
    compare("wrap_tx_count", tx_count, 16'h0001);

    // Reset mid-traffic, then idle
    rand_prod = 1; budget = 10; rand_rdy = 1;
    runCycles(23);
    doReset();
    rand_rdy = 0;
    e0 = en_log.size(); r0 = ren_log.size();
    runCycles(50);
    compare("post_reset_ren", ren_log.size() - r0, 0);
    compare("post_reset_en", en_log.size() - e0, 0);
    compare("post_reset_count", tx_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/tx_scheduler.md
Name: tx_scheduler

Overview:
- Controller for the shared UART transmit path: byte FIFO followed by uart_tx.
- Arbitrates two byte producers (req0 = command responses, req1 = glitch results) onto the single FIFO write port, round-robin.
- Drains the FIFO into uart_tx, one byte per uart_tx ready window.
- Sits between the command/glitch logic and the fifo + uart_tx instances; owns every wen/ren/en strobe on that path.

Parameters:
- DATA_W, 8, byte width on all data ports.
- CNT_W, 16, width of the transmitted-byte counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- req0_data  in  DATA_W  producer 0 byte
- req0_valid  in  1  producer 0 has a byte
- req0_ready  out  1  producer 0 byte accepted this cycle
- req1_data  in  DATA_W  producer 1 byte
- req1_valid  in  1  producer 1 has a byte
- req1_ready  out  1  producer 1 byte accepted this cycle
- fifo_data_in  out  DATA_W  FIFO write data
- fifo_wen  out  1  FIFO write strobe
- fifo_full  in  1  FIFO full
- fifo_ren  out  1  FIFO read strobe
- fifo_data_out  in  DATA_W  FIFO read data; valid 1 cycle after fifo_ren
- fifo_empty  in  1  FIFO empty
- tx_data  out  DATA_W  byte to uart_tx
- tx_en  out  1  uart_tx start pulse
- tx_rdy  in  1  uart_tx idle and able to accept
- drain_en  in  1  1 = drain FIFO to UART; 0 = pause after the current byte
- tx_count  out  CNT_W  bytes handed to uart_tx since reset

Behaviour:
- Reset (async assert, sync release to clk):
  - All outputs 0; tx_data = 0; tx_count = 0.
  - Drain FSM = IDLE; round-robin pointer = 0, so req0 has priority on the first contention.
- Write arbiter (combinational grant, registered pointer):
  - Only one valid: that requester is granted.
  - Both valid: the requester other than the last one served is granted.
  - fifo_wen = granted valid & ~fifo_full.
  - fifo_data_in = granted data.
  - reqN_ready = grant to N & ~fifo_full; this is the same-cycle accept.
  - Pointer updates only on an accepted write.
  - fifo_full = 1: no ready, no wen, pointer held.
  - Producers hold data and valid until they see ready.
- Drain FSM:
  - IDLE: if drain_en & ~fifo_empty, assert fifo_ren for exactly 1 cycle and go to FETCH. Otherwise stay.
  - FETCH: 1 cycle. Latch fifo_data_out into tx_data at the end of the cycle, then go to SEND.
  - SEND: wait for tx_rdy. When tx_rdy = 1, pulse tx_en for 1 cycle, increment tx_count, go to GUARD.
  - GUARD: 1 cycle with tx_rdy ignored, covering uart_tx's 1-cycle rdy drop. Then go to IDLE.
- Latency: IDLE with data to tx_en is minimum 2 cycles (ren, fetch, en). Throughput is bounded by uart_tx.
- Boundaries:
  - A read is never issued when fifo_empty = 1.
  - drain_en deasserted in FETCH/SEND: the fetched byte is still sent; the pause applies from IDLE.
  - Simultaneous fifo_wen and fifo_ren is legal; the scheduler takes no special action.
  - A FIFO write when full is impossible by construction.
  - tx_count wraps modulo 2^CNT_W.
  - tx_data holds its value between sends.
  - Reset asserted mid-byte aborts the FSM to IDLE. A byte already popped from the FIFO is discarded; this is accepted.

Decomposition:
- Shared package tx_pkg:
  - drain state enum IDLE/FETCH/SEND/GUARD (2-bit);
  - DATA_W default.
- One natural sub-module: rr_arb2, the 2-way round-robin arbiter with a registered pointer and accept input.
- The drain FSM and counter stay in tx_scheduler.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately; after release, idle with fifo_empty = 1 -> no ren, no en for 50 cycles.
- Single byte: req0_data = 8'hAA with valid 1 cycle, FIFO model empty -> req0_ready = 1 and fifo_wen = 1 in the same cycle. The FIFO model must drive fifo_empty = 0 after this write. Then, with tx_rdy = 1, fifo_ren 1 cycle, tx_en 2 cycles after ren with tx_data = 8'hAA, and tx_count = 1.
- Contention: req0 = 8'h11 and req1 = 8'h22 both held valid for 4 accepts -> FIFO write order 11, 22, 11, 22; each requester sees ready exactly twice.
- Full: fifo_full = 1 with both valid -> readys and wen stay 0. Release full -> the pending grant resumes with the correct round-robin order.
- Backpressure: tx_rdy = 0 for 20 cycles while in SEND with byte 8'h5C -> no tx_en. When tx_rdy rises: a single tx_en, tx_data = 8'h5C, exactly one ren per byte, no byte lost or duplicated across a 16-byte burst.
- Pause: drop drain_en during FETCH -> that byte is still sent, then no further ren until drain_en = 1. Preload tx_count near wrap (via 2^CNT_W sends or force) -> it wraps to 0.
